// File: rtl/attn_pkg.sv
// Shared types and widths for the attention engine host master and engine top.
// Beats are numbered 0..7 per key row; bit 0 selects key (1) or query (0).
package attn_pkg;

  localparam int ATTN_FEAT  = 4;
  localparam int ATTN_DW    = 8;
  localparam int ATTN_RESW  = 9;
  localparam int ATTN_BEATS = 2 * ATTN_FEAT;
  localparam int ATTN_BW    = $clog2(ATTN_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_DONE     = 2'd3
  } attn_master_state_t;

  // Feature index carried by a beat: both q[f] and k[row][f] share it.
  function automatic logic [1:0] beat_feat(input logic [ATTN_BW-1:0] beat);
    return beat[ATTN_BW-1:1];
  endfunction

endpackage

// File: rtl/attn_operand_mux.sv
// Query and key vector storage, plus selection of the operand byte for a
// given (row, beat) position of the interleaved stream.
module attn_operand_mux
  import attn_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int RW     = $clog2(N_ROWS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_ld_en,
  input  logic               i_ld_sel,
  input  logic [RW-1:0]      i_ld_row,
  input  logic [1:0]         i_ld_col,
  input  logic [ATTN_DW-1:0] i_ld_data,
  input  logic [RW-1:0]      i_row,
  input  logic [ATTN_BW-1:0] i_beat,
  output logic [ATTN_DW-1:0] o_byte
);

  logic [ATTN_DW-1:0] r_q [ATTN_FEAT];
  logic [ATTN_DW-1:0] r_k [N_ROWS][ATTN_FEAT];
  logic [1:0]         w_feat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < ATTN_FEAT; f++) begin
        r_q[f] <= '0;
      end
    end else if (i_ld_en && !i_ld_sel) begin
      r_q[i_ld_col] <= i_ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int f = 0; f < ATTN_FEAT; f++) begin
          r_k[r][f] <= '0;
        end
      end
    end else if (i_ld_en && i_ld_sel) begin
      r_k[i_ld_row][i_ld_col] <= i_ld_data;
    end
  end

  assign w_feat = beat_feat(i_beat);
  assign o_byte = i_beat[0] ? r_k[i_row][w_feat] : r_q[w_feat];

endmodule

// File: rtl/attn_stream_master.sv
// Host master: streams q/k byte pairs to the attention engine, then collects
// one exp() score per row into a result buffer and a running denominator.
module attn_stream_master
  import attn_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int RW     = $clog2(N_ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_en,
  input  logic                    ld_sel,
  input  logic [RW-1:0]           ld_row,
  input  logic [1:0]              ld_col,
  input  logic [ATTN_DW-1:0]      ld_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ATTN_DW-1:0]      mst_data_out,
  output logic                    mst_vld_out,
  input  logic                    mst_rdy_in,
  input  logic [ATTN_RESW-1:0]    res_data_in,
  input  logic                    res_vld_in,
  output logic                    res_rdy_out,
  input  logic [RW-1:0]           rd_row,
  output logic [ATTN_RESW-1:0]    rd_data,
  output logic [ATTN_RESW+RW-1:0] sum_out
);

  localparam logic [RW-1:0]      LAST_ROW  = RW'(N_ROWS - 1);
  localparam logic [ATTN_BW-1:0] LAST_BEAT = ATTN_BW'(ATTN_BEATS - 1);

  attn_master_state_t r_state, w_state_next;
  logic [RW-1:0]           r_row, w_row_next;
  logic [ATTN_BW-1:0]      r_beat, w_beat_next;
  logic                    r_vld, w_vld_next;
  logic                    w_clear;
  logic                    w_res_we;
  logic                    w_ld_en;
  logic [ATTN_DW-1:0]      w_byte;
  logic [ATTN_RESW+RW-1:0] r_sum;
  logic [ATTN_RESW-1:0]    r_result [N_ROWS];

  assign w_ld_en = ld_en && (r_state == ST_IDLE);

  attn_operand_mux #(
    .N_ROWS (N_ROWS),
    .RW     (RW)
  ) u_operand_mux (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ld_en   (w_ld_en),
    .i_ld_sel  (ld_sel),
    .i_ld_row  (ld_row),
    .i_ld_col  (ld_col),
    .i_ld_data (ld_data),
    .i_row     (r_row),
    .i_beat    (r_beat),
    .o_byte    (w_byte)
  );

  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_beat_next  = r_beat;
    w_vld_next   = r_vld;
    w_clear      = 1'b0;
    w_res_we     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SEND;
          w_row_next   = '0;
          w_beat_next  = '0;
          w_vld_next   = 1'b1;
          w_clear      = 1'b1;
        end
      end
      ST_SEND: begin
        if (r_vld && mst_rdy_in) begin
          if (r_beat == LAST_BEAT) begin
            w_state_next = ST_WAIT_RES;
            w_vld_next   = 1'b0;
          end else begin
            w_beat_next = r_beat + 1'b1;
          end
        end
      end
      ST_WAIT_RES: begin
        if (res_vld_in) begin
          w_res_we = 1'b1;
          if (r_row == LAST_ROW) begin
            w_state_next = ST_DONE;
          end else begin
            // Next row's q0 goes out on the same edge that takes the result.
            w_state_next = ST_SEND;
            w_row_next   = r_row + 1'b1;
            w_beat_next  = '0;
            w_vld_next   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_vld_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_beat  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
      r_beat  <= w_beat_next;
      r_vld   <= w_vld_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_clear) begin
      r_sum <= '0;
    end else if (w_res_we) begin
      r_sum <= r_sum + {{RW{1'b0}}, res_data_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROWS; r++) begin
        r_result[r] <= '0;
      end
    end else if (w_clear) begin
      for (int r = 0; r < N_ROWS; r++) begin
        r_result[r] <= '0;
      end
    end else if (w_res_we) begin
      r_result[r_row] <= res_data_in;
    end
  end

  // Data is forced to zero whenever no beat is offered, so reset clears it at once.
  assign mst_data_out = r_vld ? w_byte : '0;
  assign mst_vld_out  = r_vld;
  assign res_rdy_out  = (r_state == ST_WAIT_RES);
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign rd_data      = r_result[rd_row];
  assign sum_out      = r_sum;

endmodule

// File: doc/attn_stream_master.md
# attn_stream_master

Host-side master for the credit-pipelined attention engine. Holds one query vector and N_ROWS key vectors of 4 Q0.7 features each, and streams them as interleaved byte pairs over the engine's 8-bit valid/ready input port. It then collects one 9-bit UQ3.6 exp() score per key row from the engine's output port and accumulates the softmax denominator. It is the transmitter and receiver for the engine's two handshake ports.

## Interface
- `N_ROWS`, default 4: number of key vectors per run; power of two, at least 2.
- `RW`, default $clog2(N_ROWS): row index width (derived; do not override).
- `clk`  in  1  : single clock, rising edge.
- `rst_n`  in  1  : asynchronous, active-low reset.
- `ld_en`  in  1  : load strobe; honoured only in IDLE.
- `ld_sel`  in  1  : 0 = query register, 1 = key register.
- `ld_row`  in  RW  : key row index; ignored for query.
- `ld_col`  in  2  : feature index 0..3.
- `ld_data`  in  8  : Q0.7 feature value.
- `start`  in  1  : begin a run; honoured only in IDLE.
- `busy`  out  1  : high in SEND, WAIT_RES, DONE.
- `done`  out  1  : one-cycle pulse; sum and results are final.
- `mst_data_out`  out  8  : operand byte to engine.
- `mst_vld_out`  out  1  : operand valid.
- `mst_rdy_in`  in  1  : engine ready for operand.
- `res_data_in`  in  9  : engine exp() result, UQ3.6.
- `res_vld_in`  in  1  : result valid.
- `res_rdy_out`  out  1  : master accepts result.
- `rd_row`  in  RW  : result buffer read index.
- `rd_data`  out  9  : result[rd_row], combinational.
- `sum_out`  out  9+RW  : unsigned sum of all row results.

## Operation
- States: IDLE, SEND, WAIT_RES, DONE.
- IDLE: loads write q[col] or k[row][col]; `start` clears `sum_out` and all results, sets row=0, beat=0, and moves to SEND.
- SEND, beat b in 0..7: `mst_data_out` = q[b>>1] for even b, k[row][b>>1] for odd b. Order per row is q0, k0, q1, k1, q2, k2, q3, k3.
- A beat transfers when `mst_vld_out && mst_rdy_in`. Data is held stable and `mst_vld_out` stays high until the beat transfers. No beat is skipped or repeated.
- After beat 7 transfers, go to WAIT_RES.
- WAIT_RES: `res_rdy_out`=1. On `res_vld_in && res_rdy_out`:
  - result[row] <= `res_data_in`;
  - sum <= sum + zero-extended `res_data_in`;
  - if row==N_ROWS-1, go to DONE; otherwise row++, beat=0, go to SEND.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` and `ld_en` outside IDLE are ignored; no state or register change.
- `res_vld_in` outside WAIT_RES is not acknowledged (`res_rdy_out`=0).
- Arithmetic: `sum_out` width 9+RW cannot overflow (max N_ROWS·511). `res_data_in[8]` is treated as magnitude, not sign.

## Timing
- Reset values: `mst_vld_out`=0, `mst_data_out`=0, `res_rdy_out`=0, `busy`=0, `done`=0, `sum_out`=0. Query, key and result storage all reset to 0. State is IDLE.
- Reset mid-run: all outputs take their reset values immediately (asynchronous). No partial handshake completes.
- Start latency: `start` sampled in IDLE at edge N; `mst_vld_out`=1 carrying q0 from edge N (registered output).
- With `mst_rdy_in` held high, a row's 8 beats occupy 8 consecutive cycles.
- `mst_vld_out` falls on the edge that accepts beat 7, together with the entry to WAIT_RES. `res_rdy_out` rises on that same edge.
- A result accepted at edge M:
  - next row: `mst_vld_out`=1 with the next row's q0 from edge M;
  - last row: `done`=1 during cycle M..M+1, `busy` falls at M+1.
- `rd_data` reflects a result write from the following cycle.

## Structure
- Shared package `attn_pkg`, containing:
  - state enum `attn_master_state_t`;
  - `ATTN_FEAT` = 4;
  - `ATTN_DW` = 8 (operand width);
  - `ATTN_RESW` = 9 (result width).
- The engine top also imports `attn_pkg` for these widths.
- One sub-module, `attn_operand_mux`: q/k storage plus the beat-index-to-byte select. The FSM, counters, result buffer and accumulator stay in `attn_stream_master`.

## Test plan
- Beat order: load q=[0x40,0x20,0x10,0x08] and k[0]=[0x01,0x02,0x03,0x04], `start`, `mst_rdy_in`=1 → beats 0x40,0x01,0x20,0x02,0x10,0x03,0x08,0x04 on 8 consecutive cycles.
- Backpressure: toggle `mst_rdy_in` randomly → each byte held stable while unaccepted, exactly 8 transfers per row, order as above.
- Full run: responder returns 0x040,0x080,0x0C0,0x100 for rows 0..3 → rd_data[0..3] matches, `sum_out`=0x280, `done` high exactly one cycle, `busy` low after.
- Ignored inputs: `start` and `ld_en` (writing q0=0x7F) during SEND → run unaffected; q0 remains 0x40 on the next run.
- Protocol: `res_vld_in`=1 throughout SEND → `res_rdy_out`=0, no result stored until WAIT_RES.
- Reset mid-run: deassert `rst_n` during beat 3 of row 1 → `mst_vld_out`, `busy` and `sum_out` go to 0 without waiting for a clock edge; the next `start` begins again at row 0, beat 0.
